// File: rtl/cd_sector_parser_if.sv
// Signal bundle between the sector cache word stream, the sector parser,
// the CDIC sector buffer RAM write port and the CDIC control status lines.
interface cd_sector_parser_if #(
    parameter int BANK_AW = 11
);
    logic [15:0]      cd_data;
    logic             cd_data_valid;
    logic             sector_delivered;
    logic [1:0]       bank_release;

    logic [BANK_AW:0] buf_addr;
    logic [15:0]      buf_data;
    logic             buf_we;

    logic             sector_done;
    logic             done_bank;
    logic             sync_ok;
    logic             len_err;
    logic [23:0]      hdr_msf;
    logic [7:0]       hdr_mode;
    logic [31:0]      subhdr;
    logic             overrun;
    logic [1:0]       bank_busy;

    modport master (
        input  cd_data, cd_data_valid, sector_delivered, bank_release,
        output buf_addr, buf_data, buf_we,
        output sector_done, done_bank, sync_ok, len_err,
        output hdr_msf, hdr_mode, subhdr, overrun, bank_busy
    );

    modport slave (
        output cd_data, cd_data_valid, sector_delivered, bank_release,
        input  buf_addr, buf_data, buf_we,
        input  sector_done, done_bank, sync_ok, len_err,
        input  hdr_msf, hdr_mode, subhdr, overrun, bank_busy
    );
endinterface

// File: rtl/cd_sector_parser.sv
// Checks sector sync, decodes header/subheader, writes each sector into one of
// two ping-pong buffer banks and reports per-sector status to CDIC control.
module cd_sector_parser #(
    parameter int SECTOR_WORDS = 1188,
    parameter int BANK_AW      = 11
) (
    input  logic               clk,
    input  logic               reset,
    cd_sector_parser_if.master bus
);

    localparam logic [10:0] SECTOR_LEN = 11'(SECTOR_WORDS);
    localparam logic [10:0] IDX_MAX    = 11'h7FF;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HEADER,
        BODY,
        DROP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [10:0] word_idx;
    logic [10:0] idx_upd;
    logic        cur_bank;
    logic        sector_bank;
    logic        pick_bank;
    logic        wr_bank;

    logic        sync_acc;
    logic        sync_acc_upd;
    logic        excess;
    logic        excess_upd;
    logic [15:0] sync_expect;
    logic        in_sync;

    logic [23:0] msf_lat;
    logic [23:0] msf_upd;
    logic [7:0]  mode_lat;
    logic [7:0]  mode_upd;
    logic [31:0] sub_lat;
    logic [31:0] sub_upd;

    logic        word_accept;
    logic        word_write;
    logic        start_sector;
    logic        start_drop;
    logic        finish;
    logic [1:0]  set_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bank occupancy is only consulted on the first word; a sector that
    // finds both banks busy is dropped as a whole.
    always_comb begin
        next_state   = state;
        word_accept  = 1'b0;
        start_sector = 1'b0;
        start_drop   = 1'b0;
        finish       = 1'b0;
        pick_bank    = cur_bank;

        case (state)
            IDLE: begin
                if (bus.cd_data_valid) begin
                    if (!bus.bank_busy[cur_bank]) begin
                        pick_bank    = cur_bank;
                        start_sector = 1'b1;
                        word_accept  = 1'b1;
                        next_state   = SYNC;
                    end else if (!bus.bank_busy[~cur_bank]) begin
                        pick_bank    = ~cur_bank;
                        start_sector = 1'b1;
                        word_accept  = 1'b1;
                        next_state   = SYNC;
                    end else begin
                        start_drop = 1'b1;
                        next_state = DROP;
                    end
                end
            end
            SYNC, HEADER, BODY: begin
                word_accept = bus.cd_data_valid;
                if (bus.sector_delivered) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else if (bus.cd_data_valid && state == SYNC && word_idx == 11'd5) begin
                    next_state = HEADER;
                end else if (bus.cd_data_valid && state == HEADER && word_idx == 11'd11) begin
                    next_state = BODY;
                end
            end
            DROP: begin
                if (bus.sector_delivered) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Per-word updates, computed so that a word arriving with the end-of-sector
    // pulse is already folded into the published status.
    always_comb begin
        wr_bank      = (state == IDLE) ? pick_bank : sector_bank;
        in_sync      = (word_idx < 11'd6);
        sync_expect  = 16'h0000;
        idx_upd      = word_idx;
        sync_acc_upd = start_sector ? 1'b1 : sync_acc;
        excess_upd   = start_sector ? 1'b0 : excess;
        msf_upd      = start_sector ? 24'h0 : msf_lat;
        mode_upd     = start_sector ? 8'h0 : mode_lat;
        sub_upd      = start_sector ? 32'h0 : sub_lat;
        word_write   = 1'b0;

        case (word_idx)
            11'd0:                      sync_expect = 16'h00FF;
            11'd1, 11'd2, 11'd3, 11'd4: sync_expect = 16'hFFFF;
            11'd5:                      sync_expect = 16'hFF00;
            default:                    sync_expect = 16'h0000;
        endcase

        if (word_accept) begin
            if (word_idx != IDX_MAX) begin
                idx_upd = word_idx + 11'd1;
            end
            if (in_sync && bus.cd_data != sync_expect) begin
                sync_acc_upd = 1'b0;
            end
            if (word_idx < SECTOR_LEN) begin
                word_write = 1'b1;
            end else begin
                excess_upd = 1'b1;
            end
            case (word_idx)
                11'd6: msf_upd[23:8] = bus.cd_data;
                11'd7: begin
                    msf_upd[7:0] = bus.cd_data[15:8];
                    mode_upd     = bus.cd_data[7:0];
                end
                11'd8:   sub_upd[31:16] = bus.cd_data;
                11'd9:   sub_upd[15:0]  = bus.cd_data;
                default: ;
            endcase
        end

        set_mask = 2'b00;
        if (finish) begin
            set_mask = sector_bank ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx    <= 11'h0;
            cur_bank    <= 1'b0;
            sector_bank <= 1'b0;
            sync_acc    <= 1'b0;
            excess      <= 1'b0;
            msf_lat     <= 24'h0;
            mode_lat    <= 8'h0;
            sub_lat     <= 32'h0;
        end else begin
            word_idx <= (next_state == IDLE || next_state == DROP) ? 11'h0 : idx_upd;
            sync_acc <= sync_acc_upd;
            excess   <= excess_upd;
            msf_lat  <= msf_upd;
            mode_lat <= mode_upd;
            sub_lat  <= sub_upd;
            if (start_sector) begin
                sector_bank <= pick_bank;
            end
            if (finish) begin
                cur_bank <= ~sector_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.buf_we   <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_data <= 16'h0;
        end else begin
            bus.buf_we <= word_write;
            if (word_write) begin
                bus.buf_addr <= {wr_bank, BANK_AW'(word_idx)};
                bus.buf_data <= bus.cd_data;
            end
        end
    end

    // A release landing in the same clock as a set of that bank loses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sector_done <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.done_bank   <= 1'b0;
            bus.sync_ok     <= 1'b0;
            bus.len_err     <= 1'b0;
            bus.hdr_msf     <= 24'h0;
            bus.hdr_mode    <= 8'h0;
            bus.subhdr      <= 32'h0;
            bus.bank_busy   <= 2'b00;
        end else begin
            bus.sector_done <= finish;
            bus.overrun     <= start_drop;
            bus.bank_busy   <= (bus.bank_busy & ~bus.bank_release) | set_mask;
            if (finish) begin
                bus.done_bank <= sector_bank;
                bus.sync_ok   <= sync_acc_upd & (idx_upd >= 11'd6);
                bus.len_err   <= (idx_upd != SECTOR_LEN) | excess_upd;
                bus.hdr_msf   <= msf_upd;
                bus.hdr_mode  <= mode_upd;
                bus.subhdr    <= sub_upd;
            end
        end
    end

endmodule

// File: tb/tb_cd_sector_parser.sv
// Directed bench for cd_sector_parser: a table of whole-sector scenarios plus
// hand-written reset-abort and coincident-release sequences.
module tb_cd_sector_parser;

    localparam int SECTOR_WORDS = 1188;
    localparam int BANK_AW      = 11;
    localparam int LOG_DEPTH    = 16384;
    localparam int NUM_VECS     = 8;

    typedef struct {
        string      name;
        int         n_words;
        bit         bad_sync;
        bit         coincide;
        logic [1:0] rel_before;
        logic [1:0] rel_mid;
        logic [1:0] rel_end;
        logic [7:0] sec;
        bit         exp_drop;
        bit         exp_bank;
        bit         exp_sync;
        bit         exp_len;
        int         exp_writes;
        logic [1:0] exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    int   checks = 0;
    int   errors = 0;

    int   wr_total = 0;
    int   done_total = 0;
    int   ovr_total = 0;
    int   done_cyc = 0;
    int   ovr_cyc = 0;
    logic [11:0] log_addr [0:LOG_DEPTH-1];
    logic [15:0] log_data [0:LOG_DEPTH-1];
    logic        snap_bank;
    logic        snap_sync;
    logic        snap_len;
    logic [23:0] snap_msf;
    logic [7:0]  snap_mode;
    logic [31:0] snap_sub;

    int   wr_base;
    int   done_base;
    int   ovr_base;
    int   sample_cyc;
    int   first_cyc;
    int   deliver_cyc;

    vec_t vecs [NUM_VECS];
    vec_t hv;

    cd_sector_parser_if #(.BANK_AW(BANK_AW)) bus ();

    cd_sector_parser #(
        .SECTOR_WORDS(SECTOR_WORDS),
        .BANK_AW     (BANK_AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs every RAM write and snapshots status on sector_done.
    always @(negedge clk) begin
        if (bus.buf_we) begin
            if (wr_total < LOG_DEPTH) begin
                log_addr[wr_total] <= bus.buf_addr;
                log_data[wr_total] <= bus.buf_data;
            end
            wr_total <= wr_total + 1;
        end
        if (bus.sector_done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
            snap_bank  <= bus.done_bank;
            snap_sync  <= bus.sync_ok;
            snap_len   <= bus.len_err;
            snap_msf   <= bus.hdr_msf;
            snap_mode  <= bus.hdr_mode;
            snap_sub   <= bus.subhdr;
        end
        if (bus.overrun) begin
            ovr_total <= ovr_total + 1;
            ovr_cyc   <= cyc;
        end
    end

    function automatic logic [15:0] word_of(input int i, input bit bad, input logic [7:0] sec);
        case (i)
            0:       return 16'h00FF;
            1, 2, 4: return 16'hFFFF;
            3:       return bad ? 16'hFFFE : 16'hFFFF;
            5:       return 16'hFF00;
            6:       return {8'h00, sec};
            7:       return 16'h1602;
            8, 10:   return 16'h0100;
            9, 11:   return 16'h6400;
            default: return 16'((i * 37) ^ 16'h5A3C);
        endcase
    endfunction

    function automatic vec_t mkVec(input string name, input int n, input bit bad, input bit co,
                                   input logic [1:0] rb, input logic [1:0] rm, input logic [1:0] re,
                                   input logic [7:0] sec, input bit drop, input bit bank,
                                   input bit sync, input bit len, input int wr, input logic [1:0] busy);
        vec_t v;
        v.name = name;      v.n_words = n;     v.bad_sync = bad;  v.coincide = co;
        v.rel_before = rb;  v.rel_mid = rm;    v.rel_end = re;    v.sec = sec;
        v.exp_drop = drop;  v.exp_bank = bank; v.exp_sync = sync; v.exp_len = len;
        v.exp_writes = wr;  v.exp_busy = busy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendWord(input logic [15:0] w, input bit deliver, input logic [1:0] rel);
        bus.cd_data          = w;
        bus.cd_data_valid    = 1'b1;
        bus.sector_delivered = deliver;
        bus.bank_release     = rel;
        @(posedge clk);
        #1;
        sample_cyc           = cyc;
        bus.cd_data_valid    = 1'b0;
        bus.sector_delivered = 1'b0;
        bus.bank_release     = 2'b00;
        idle(3);
    endtask

    task automatic pulseDeliver(input logic [1:0] rel);
        bus.sector_delivered = 1'b1;
        bus.bank_release     = rel;
        @(posedge clk);
        #1;
        deliver_cyc          = cyc;
        bus.sector_delivered = 1'b0;
        bus.bank_release     = 2'b00;
        idle(3);
    endtask

    task automatic pulseRelease(input logic [1:0] rel);
        bus.bank_release = rel;
        @(posedge clk);
        #1;
        bus.bank_release = 2'b00;
        idle(1);
    endtask

    task automatic markBases();
        wr_base   = wr_total;
        done_base = done_total;
        ovr_base  = ovr_total;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit last;
        logic [1:0] rel;
        if (v.rel_before != 2'b00) pulseRelease(v.rel_before);
        markBases();
        for (int i = 0; i < v.n_words; i++) begin
            last = (i == v.n_words - 1);
            rel  = (v.coincide && last) ? v.rel_end : ((i == 10) ? v.rel_mid : 2'b00);
            sendWord(word_of(i, v.bad_sync, v.sec), v.coincide && last, rel);
            if (i == 0) first_cyc = sample_cyc;
            if (v.coincide && last) deliver_cyc = sample_cyc;
        end
        if (!v.coincide) pulseDeliver(v.rel_end);
        idle(2);
    endtask

    task automatic checkSector(input vec_t v);
        int n_wr;
        int bad;
        logic [11:0] ea;
        n_wr = wr_total - wr_base;
        checkOutput({v.name, "/writes"}, n_wr, v.exp_writes);
        bad = 0;
        for (int k = 0; k < n_wr && k < v.exp_writes; k++) begin
            ea = {v.exp_bank, 11'(k)};
            if (log_addr[wr_base + k] !== ea || log_data[wr_base + k] !== word_of(k, v.bad_sync, v.sec))
                bad++;
        end
        if (v.exp_writes > 0) checkOutput({v.name, "/write_log_bad"}, bad, 0);
        if (v.exp_drop) begin
            checkOutput({v.name, "/done_count"}, done_total - done_base, 0);
            checkOutput({v.name, "/overrun_count"}, ovr_total - ovr_base, 1);
            checkOutput({v.name, "/overrun_cycle"}, ovr_cyc, first_cyc);
        end else begin
            checkOutput({v.name, "/done_count"}, done_total - done_base, 1);
            checkOutput({v.name, "/done_cycle"}, done_cyc, deliver_cyc);
            checkOutput({v.name, "/done_bank"}, snap_bank, v.exp_bank);
            checkOutput({v.name, "/sync_ok"}, snap_sync, v.exp_sync);
            checkOutput({v.name, "/len_err"}, snap_len, v.exp_len);
            checkOutput({v.name, "/hdr_msf"}, snap_msf, {8'h00, v.sec, 8'h16});
            checkOutput({v.name, "/hdr_mode"}, snap_mode, 8'h02);
            checkOutput({v.name, "/subhdr"}, snap_sub, 32'h0100_6400);
            checkOutput({v.name, "/overrun_count"}, ovr_total - ovr_base, 0);
        end
        checkOutput({v.name, "/bank_busy"}, bus.bank_busy, v.exp_busy);
    endtask

    initial begin
        reset                = 1'b1;
        bus.cd_data          = 16'h0;
        bus.cd_data_valid    = 1'b0;
        bus.sector_delivered = 1'b0;
        bus.bank_release     = 2'b00;
        idle(3);

        checkOutput("reset/buf_we", bus.buf_we, 0);
        checkOutput("reset/buf_addr", bus.buf_addr, 0);
        checkOutput("reset/sector_done", bus.sector_done, 0);
        checkOutput("reset/overrun", bus.overrun, 0);
        checkOutput("reset/bank_busy", bus.bank_busy, 0);
        checkOutput("reset/status", {bus.sync_ok, bus.len_err, bus.done_bank}, 0);
        checkOutput("reset/hdr_msf", bus.hdr_msf, 0);
        checkOutput("reset/subhdr", bus.subhdr, 0);
        reset = 1'b0;
        idle(2);

        //                 name            n     bad co  rb     rm     re     sec    drop bank sync len writes busy
        vecs[0] = mkVec("good",          1188, 0, 0, 2'b00, 2'b00, 2'b00, 8'h02, 0,   0,   1,   0,  1188, 2'b01);
        vecs[1] = mkVec("second_good",   1188, 0, 0, 2'b00, 2'b00, 2'b00, 8'h03, 0,   1,   1,   0,  1188, 2'b11);
        vecs[2] = mkVec("overrun",       1188, 0, 0, 2'b00, 2'b01, 2'b00, 8'h04, 1,   0,   0,   0,  0,    2'b10);
        vecs[3] = mkVec("after_release", 1188, 0, 0, 2'b00, 2'b00, 2'b00, 8'h05, 0,   0,   1,   0,  1188, 2'b11);
        vecs[4] = mkVec("bad_sync",      1188, 1, 0, 2'b10, 2'b00, 2'b00, 8'h06, 0,   1,   0,   0,  1188, 2'b11);
        vecs[5] = mkVec("short",         1000, 0, 0, 2'b01, 2'b00, 2'b00, 8'h07, 0,   0,   1,   1,  1000, 2'b11);
        vecs[6] = mkVec("long",          1200, 0, 0, 2'b10, 2'b00, 2'b00, 8'h08, 0,   1,   1,   1,  1188, 2'b11);
        vecs[7] = mkVec("coincide_last", 1188, 0, 1, 2'b01, 2'b00, 2'b00, 8'h09, 0,   0,   1,   0,  1188, 2'b11);

        for (int k = 0; k < NUM_VECS; k++) begin
            applyStimulus(vecs[k]);
            checkSector(vecs[k]);
        end

        // Reset after word 500 of a sector heading into bank 1.
        pulseRelease(2'b11);
        markBases();
        for (int i = 0; i < 500; i++) sendWord(word_of(i, 1'b0, 8'h10), 1'b0, 2'b00);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(4);
        checkOutput("abort/writes", wr_total - wr_base, 500);
        checkOutput("abort/first_addr", log_addr[wr_base], 12'h800);
        checkOutput("abort/done_count", done_total - done_base, 0);
        checkOutput("abort/bank_busy", bus.bank_busy, 2'b00);
        checkOutput("abort/sync_ok", bus.sync_ok, 0);
        checkOutput("abort/hdr_msf", bus.hdr_msf, 0);
        hv = mkVec("post_reset", 1188, 0, 0, 2'b00, 2'b00, 2'b00, 8'h11, 0, 0, 1, 0, 1188, 2'b01);
        applyStimulus(hv);
        checkSector(hv);

        // Release of bank 0 in the same clock bank 0 gets set: set wins.
        hv = mkVec("tiny", 20, 0, 0, 2'b00, 2'b00, 2'b00, 8'h12, 0, 1, 1, 1, 20, 2'b11);
        applyStimulus(hv);
        checkSector(hv);
        hv = mkVec("release_vs_set", 1188, 0, 0, 2'b01, 2'b00, 2'b01, 8'h13, 0, 0, 1, 0, 1188, 2'b11);
        applyStimulus(hv);
        checkSector(hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
